// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer driving a shared 8-bit ALU.
// Multiply is shift-add (3 ALU ops per bit); divide is restoring (4 ALU ops per bit).
module alu_muldiv_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [7:0]  i_opa,
  input  logic [7:0]  i_opb,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_result,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [3:0]  o_alu_mode,
  output logic        o_alu_cin,
  input  logic [7:0]  i_alu_out,
  input  logic        i_alu_cout
);

  typedef enum logic [3:0] {
    StIdle, StMulAdd, StMulRh, StMulRl, StDivSl, StDivRl, StDivSub, StDivOr, StDone
  } state_e;

  state_e      r_state;
  logic [7:0]  r_m, r_hi, r_lo;
  logic        r_c, r_acc;
  logic [2:0]  r_cnt;
  logic        r_busy, r_done, r_err;
  logic [15:0] r_result;
  logic        w_acc;

  // ALU carry-out on SUB is the borrow: subtract succeeds if the 9th bit is set or no borrow.
  assign w_acc = r_c | ~i_alu_cout;

  always_comb begin
    o_alu_a    = 8'h00;
    o_alu_b    = 8'h00;
    o_alu_mode = 4'b0000;
    o_alu_cin  = 1'b0;
    unique case (r_state)
      StMulAdd: begin
        o_alu_mode = 4'b0101;
        o_alu_a    = r_hi;
        o_alu_b    = r_lo[0] ? r_m : 8'h00;
      end
      StMulRh: begin
        o_alu_mode = 4'b1110;
        o_alu_a    = r_hi;
        o_alu_cin  = r_c;
      end
      StMulRl: begin
        o_alu_mode = 4'b1110;
        o_alu_a    = r_lo;
        o_alu_cin  = r_c;
      end
      StDivSl: begin
        o_alu_mode = 4'b1010;
        o_alu_a    = r_lo;
      end
      StDivRl: begin
        o_alu_mode = 4'b1101;
        o_alu_a    = r_hi;
        o_alu_cin  = r_c;
      end
      StDivSub: begin
        o_alu_mode = 4'b1000;
        o_alu_a    = r_hi;
        o_alu_b    = r_m;
      end
      StDivOr: begin
        o_alu_mode = 4'b0011;
        o_alu_a    = r_lo;
        o_alu_b    = {7'b0, r_acc};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_m      <= 8'h00;
      r_hi     <= 8'h00;
      r_lo     <= 8'h00;
      r_c      <= 1'b0;
      r_acc    <= 1'b0;
      r_cnt    <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 16'h0000;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            r_hi   <= 8'h00;
            r_cnt  <= 3'd0;
            if (!i_op) begin
              r_m     <= i_opa;
              r_lo    <= i_opb;
              r_state <= StMulAdd;
            end else if (i_opb == 8'h00) begin
              r_result <= {i_opa, 8'hFF};
              r_err    <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else begin
              r_m     <= i_opb;
              r_lo    <= i_opa;
              r_state <= StDivSl;
            end
          end
        end
        StMulAdd: begin
          r_hi    <= i_alu_out;
          r_c     <= i_alu_cout;
          r_state <= StMulRh;
        end
        StMulRh: begin
          r_hi    <= i_alu_out;
          r_c     <= i_alu_cout;
          r_state <= StMulRl;
        end
        StMulRl: begin
          r_lo <= i_alu_out;
          // Result is loaded on the way into DONE so it is valid alongside the done pulse.
          if (r_cnt == 3'd7) begin
            r_result <= {r_hi, i_alu_out};
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= StMulAdd;
          end
        end
        StDivSl: begin
          r_lo    <= i_alu_out;
          r_c     <= i_alu_cout;
          r_state <= StDivRl;
        end
        StDivRl: begin
          r_hi    <= i_alu_out;
          r_c     <= i_alu_cout;
          r_state <= StDivSub;
        end
        StDivSub: begin
          r_acc <= w_acc;
          if (w_acc) r_hi <= i_alu_out;
          r_state <= StDivOr;
        end
        StDivOr: begin
          r_lo <= i_alu_out;
          if (r_cnt == 3'd7) begin
            r_result <= {r_hi, i_alu_out};
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= StDivSl;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_result = r_result;

endmodule
